// File: rtl/load_store_unit.sv
// Data-memory access stage: aligns stores into byte lanes, extends loads, and
// runs a req/ack bus handshake with timeout, stalling the core until done.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  func_3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        access_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_enable,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  wait_count;
  logic        aborted;
  logic        op_load;
  logic [2:0]  op_func_3;
  logic [1:0]  op_offset;

  logic        req_any;
  logic        req_legal;
  logic        req_misaligned;
  logic        req_valid;
  logic        req_fault;
  logic [3:0]  next_byte_enable;
  logic [31:0] next_wdata;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] extended_rdata;

  // Request decode; a simultaneous load and store is treated as a load.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    req_any   = load | store;
    req_legal = 1'b0;
    if (load) begin
      req_legal = func_3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else if (store) begin
      req_legal = func_3 inside {3'b000, 3'b001, 3'b010};
    end

    req_misaligned = 1'b0;
    case (func_3[1:0])
      2'b01:   req_misaligned = address[0];
      2'b10:   req_misaligned = |address[1:0];
      default: req_misaligned = 1'b0;
    endcase

    req_valid = (state == IDLE) && req_any && req_legal && !req_misaligned;
    req_fault = (state == IDLE) && req_any && !(req_legal && !req_misaligned);
  end

  // Lane enables and replicated write data for the incoming request.
  always_comb begin
    next_byte_enable = 4'b1111;
    next_wdata       = store_data;
    case (func_3[1:0])
      2'b00: begin
        next_byte_enable = 4'b0001 << address[1:0];
        next_wdata       = {4{store_data[7:0]}};
      end
      2'b01: begin
        next_byte_enable = address[1] ? 4'b1100 : 4'b0011;
        next_wdata       = {2{store_data[15:0]}};
      end
      default: begin
        next_byte_enable = 4'b1111;
        next_wdata       = store_data;
      end
    endcase
  end

  // Load extraction uses the size and offset captured at request time.
  always_comb begin
    case (op_offset)
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = op_offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (op_func_3[1:0])
      2'b00:   extended_rdata = {{24{lane_byte[7] & ~op_func_3[2]}}, lane_byte};
      2'b01:   extended_rdata = {{16{lane_half[15] & ~op_func_3[2]}}, lane_half};
      default: extended_rdata = mem_rdata;
    endcase
  end

  assign stall        = req_valid || (state == WAIT);
  assign access_fault = req_fault || ((state == DONE) && aborted);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      wait_count      <= 8'd0;
      aborted         <= 1'b0;
      op_load         <= 1'b0;
      op_func_3       <= 3'b000;
      op_offset       <= 2'b00;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= 32'd0;
      mem_wdata       <= 32'd0;
      mem_byte_enable <= 4'd0;
      load_data       <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state           <= WAIT;
            wait_count      <= 8'd0;
            aborted         <= 1'b0;
            op_load         <= load;
            op_func_3       <= func_3;
            op_offset       <= address[1:0];
            mem_req         <= 1'b1;
            mem_we          <= !load;
            mem_addr        <= {address[31:2], 2'b00};
            mem_wdata       <= next_wdata;
            mem_byte_enable <= next_byte_enable;
          end
        end

        WAIT: begin
          // An ack on the timeout cycle still counts as a normal completion.
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (op_load) begin
              load_data <= extended_rdata;
            end
          end else if (wait_count == LAST_WAIT) begin
            state   <= DONE;
            mem_req <= 1'b0;
            aborted <= 1'b1;
            if (op_load) begin
              load_data <= 32'd0;
            end
          end else begin
            wait_count <= wait_count + 8'd1;
          end
        end

        DONE: begin
          state   <= IDLE;
          aborted <= 1'b0;
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
